// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Program-memory loader for the Jac1-8 core. Accepts decoded
//            instruction fields over a valid/ready handshake, packs them into
//            the 16-bit instruction word and writes consecutive words to
//            program memory starting at address 0. Reserved opcodes abort the
//            session; running past the top address aborts with an overflow.
// Ports    : clk, rst_n                 - clock / async active-low reset
//            start                      - begin a session (IDLE/DONE/ERR only)
//            in_valid, in_ready, in_last- field handshake, last-word marker
//            in_opcode, in_op1, in_op2, in_param - decoded instruction fields
//            pm_wr_en, pm_addr, pm_wr_data      - program-memory write port
//            word_count                 - words written this session
//            done, err, err_code        - sticky session status
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int SEL_WIDTH         = 2,
  parameter int ParamBits         = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [NumOpCodeBits-1:0]     in_opcode,
  input  logic [SEL_WIDTH-1:0]         in_op1,
  input  logic [SEL_WIDTH-1:0]         in_op2,
  input  logic [ParamBits-1:0]         in_param,
  output logic                         pm_wr_en,
  output logic [PC_WIDTH-1:0]          pm_addr,
  output logic [PROGRAM_DataWidth-1:0] pm_wr_data,
  output logic [PC_WIDTH:0]            word_count,
  output logic                         done,
  output logic                         err,
  output logic [1:0]                   err_code
);

  // Field positions inside the instruction word
  localparam int OPC_LSB = PROGRAM_DataWidth - NumOpCodeBits;
  localparam int OP1_LSB = 8;
  localparam int OP2_LSB = 3;

  localparam logic [PC_WIDTH-1:0] ADDR_MAX = '1;

  localparam logic [1:0] ERR_RESERVED = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t state, state_next;

  logic [PROGRAM_DataWidth-1:0] packed_word;
  logic                         opcode_legal;
  logic                         last_q;

  // --------------------------------------------------------------------------
  // Instruction packing: only the fields belonging to the opcode's class are
  // placed, so unused operand inputs can never leak into the word.
  // --------------------------------------------------------------------------
  always_comb begin
    packed_word  = '0;
    opcode_legal = 1'b1;
    packed_word[OPC_LSB +: NumOpCodeBits] = in_opcode;
    case (in_opcode)
      5'b00000: packed_word = '0;                             // NOP
      5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b10011, 5'b10100, 5'b10101: begin           // R-class
        packed_word[OP1_LSB +: SEL_WIDTH] = in_op1;
        packed_word[OP2_LSB +: SEL_WIDTH] = in_op2;
      end
      5'b00111, 5'b01000, 5'b01001: begin                     // I-class
        packed_word[OP1_LSB +: SEL_WIDTH] = in_op1;
        packed_word[0 +: ParamBits]       = in_param;
      end
      5'b10000, 5'b10001, 5'b10010: begin                     // J-class
        packed_word[0 +: ParamBits] = in_param;
      end
      default: begin                                          // reserved
        packed_word  = '0;
        opcode_legal = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state and state-decoded outputs. in_ready and pm_wr_en come
  // straight from the state register, so an async reset drops them at once.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    pm_wr_en   = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_next = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_next = opcode_legal ? WRITE : ERR;
      end
      WRITE: begin
        pm_wr_en = 1'b1;
        if (last_q)                  state_next = DONE;
        else if (pm_addr == ADDR_MAX) state_next = ERR;
        else                         state_next = ACCEPT;
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address, latched word, counters and sticky status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_addr    <= '0;
      pm_wr_data <= '0;
      last_q     <= 1'b0;
      word_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            pm_addr    <= '0;
            word_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            if (opcode_legal) begin
              pm_wr_data <= packed_word;
              last_q     <= in_last;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_RESERVED;
            end
          end
        end
        WRITE: begin
          word_count <= word_count + (PC_WIDTH+1)'(1);
          if (last_q) begin
            done <= 1'b1;
          end else if (pm_addr == ADDR_MAX) begin
            // Top address reached without a last marker: no wrap.
            err      <= 1'b1;
            err_code <= ERR_OVERFLOW;
          end else begin
            pm_addr <= pm_addr + PC_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder. Drives directed and
//            randomized instruction streams, records every program-memory
//            write and compares against a word-packing reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [4:0]  in_opcode;
  logic [1:0]  in_op1;
  logic [1:0]  in_op2;
  logic [7:0]  in_param;
  logic        pm_wr_en;
  logic [7:0]  pm_addr;
  logic [15:0] pm_wr_data;
  logic [8:0]  word_count;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  instr_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_opcode  (in_opcode),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .in_param   (in_param),
    .pm_wr_en   (pm_wr_en),
    .pm_addr    (pm_addr),
    .pm_wr_data (pm_wr_data),
    .word_count (word_count),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // Write monitor: records each write, its cycle, and back-to-back strobes.
  int          cyc = 0;
  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  int          consec = 0;
  logic        prev_wr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pm_wr_en) begin
      wa_q.push_back(pm_addr);
      wd_q.push_back(pm_wr_data);
      wc_q.push_back(cyc);
      if (prev_wr) consec <= consec + 1;
    end
    prev_wr <= pm_wr_en;
  end

  // ---------------- reference model ----------------
  // 0 NOP, 1 R, 2 I, 3 J, 4 reserved
  function automatic int op_class(input int op);
    if (op == 0) return 0;
    if ((op >= 1 && op <= 6) || (op >= 19 && op <= 21)) return 1;
    if (op >= 7 && op <= 9) return 2;
    if (op >= 16 && op <= 18) return 3;
    return 4;
  endfunction

  function automatic logic [15:0] model_word(input int op, input int a, input int b, input int p);
    case (op_class(op))
      1:       return 16'(op * 2048 + a * 256 + b * 8);
      2:       return 16'(op * 2048 + a * 256 + p);
      3:       return 16'(op * 2048 + p);
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns #1 after the handshake edge (i.e. inside the following cycle).
  task automatic send(input int op, input int a, input int b, input int p, input logic last);
    int n = 0;
    in_opcode = 5'(op); in_op1 = 2'(a); in_op2 = 2'(b); in_param = 8'(p);
    in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_op1 = 2'($urandom); in_op2 = 2'($urandom); in_param = 8'($urandom);
  endtask

  task automatic check_log(input string name, input logic [7:0] ea[$], input logic [15:0] ed[$]);
    checks++;
    if (wa_q.size() !== ea.size()) begin
      errors++;
      $display("FAIL %s_count: writes=%0d required %0d", name, wa_q.size(), ea.size());
    end else begin
      foreach (ea[i]) begin
        checks++;
        if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
          errors++;
          $display("FAIL %s_word%0d: addr=%0d data=%h required addr=%0d data=%h",
                   name, i, wa_q[i], wd_q[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; #12;
    checks++;
    if ({in_ready, pm_wr_en, done, err} !== 4'b0 || pm_addr !== 8'd0 || pm_wr_data !== 16'd0 ||
        word_count !== 9'd0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL reset: rdy=%b we=%b done=%b err=%b addr=%0d data=%h cnt=%0d code=%0d required all 0",
               in_ready, pm_wr_en, done, err, pm_addr, pm_wr_data, word_count, err_code);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL idle_ready: in_ready=%b required 0", in_ready);
    end
  endtask

  task automatic test_single_add();
    clear_log();
    do_start();
    send(1, 1, 2, 8'hFF, 1'b1);
    checks++;
    if (pm_wr_en !== 1'b1 || pm_addr !== 8'd0 || pm_wr_data !== 16'h0910 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_write: we=%b addr=%0d data=%h rdy=%b required 1 0 0910 0",
               pm_wr_en, pm_addr, pm_wr_data, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (pm_wr_en !== 1'b0 || done !== 1'b1 || err !== 1'b0 || word_count !== 9'd1) begin
      errors++;
      $display("FAIL add_done: we=%b done=%b err=%b cnt=%0d required 0 1 0 1",
               pm_wr_en, done, err, word_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ea[$];
    logic [15:0] ed[$];
    clear_log();
    do_start();
    send(9, 3, 2, 8'hA5, 1'b0);
    send(16, 3, 3, 8'h3F, 1'b1);
    repeat (2) @(posedge clk); #1;
    ea = '{8'd0, 8'd1};
    ed = '{16'h4BA5, 16'h803F};
    check_log("two_words", ea, ed);
    checks++;
    if (wc_q.size() == 2 && (wc_q[1] - wc_q[0]) !== 2) begin
      errors++;
      $display("FAIL throughput: gap=%0d required 2", wc_q[1] - wc_q[0]);
    end
    checks++;
    if (done !== 1'b1 || word_count !== 9'd2) begin
      errors++; $display("FAIL two_done: done=%b cnt=%0d required 1 2", done, word_count);
    end
  endtask

  task automatic test_reserved();
    logic [7:0]  ea[$];
    logic [15:0] ed[$];
    clear_log();
    do_start();
    send(7, 1, 3, 8'h05, 1'b0);
    send(10, 2, 2, 8'h77, 1'b0);
    checks++;
    if (err !== 1'b1 || err_code !== 2'b01 || word_count !== 9'd1 || done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reserved: err=%b code=%0d cnt=%0d done=%b rdy=%b required 1 1 1 0 0",
               err, err_code, word_count, done, in_ready);
    end
    repeat (3) @(posedge clk); #1;
    ea = '{8'd0};
    ed = '{16'h3905};
    check_log("reserved", ea, ed);
  endtask

  task automatic test_overflow();
    int n = 0;
    int bad = 0;
    clear_log();
    do_start();
    in_opcode = 5'd0; in_op1 = 2'd3; in_op2 = 2'd3; in_param = 8'hFF;
    in_last = 1'b0; in_valid = 1'b1;
    while (!err && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || err_code !== 2'b10 || word_count !== 9'd256 || pm_addr !== 8'd255 || done !== 1'b0) begin
      errors++;
      $display("FAIL overflow: err=%b code=%0d cnt=%0d addr=%0d done=%b required 1 2 256 255 0",
               err, err_code, word_count, pm_addr, done);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (wa_q.size() !== 256) begin
      errors++; $display("FAIL overflow_writes: writes=%0d required 256", wa_q.size());
    end else begin
      foreach (wa_q[i]) begin
        if (wa_q[i] !== 8'(i) || wd_q[i] !== 16'h0000) bad++;
        if (i > 0 && (wc_q[i] - wc_q[i-1]) != 2) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL overflow_seq: bad_entries=%0d required 0", bad);
      end
    end
    checks++;
    if (pm_addr !== 8'd255) begin
      errors++; $display("FAIL overflow_nowrap: addr=%0d required 255", pm_addr);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0]  ea[$];
    logic [15:0] ed[$];
    do_start();
    send(1, 1, 1, 0, 1'b0);
    send(2, 2, 1, 0, 1'b0);
    checks++;
    if (pm_wr_en !== 1'b1 || pm_addr !== 8'd1) begin
      errors++; $display("FAIL pre_reset_write: we=%b addr=%0d required 1 1", pm_wr_en, pm_addr);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (pm_wr_en !== 1'b0 || pm_addr !== 8'd0 || word_count !== 9'd0 || pm_wr_data !== 16'd0 ||
        done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: we=%b addr=%0d cnt=%0d data=%h done=%b err=%b rdy=%b required all 0",
               pm_wr_en, pm_addr, word_count, pm_wr_data, done, err, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
    do_start();
    send(6, 3, 1, 0, 1'b1);
    repeat (2) @(posedge clk); #1;
    ea = '{8'd0};
    ed = '{model_word(6, 3, 1, 0)};
    check_log("after_reset", ea, ed);
  endtask

  task automatic test_start_ignored();
    do_start();
    send(3, 2, 1, 0, 1'b0);
    @(posedge clk); #1;
    do_start();
    checks++;
    if (in_ready !== 1'b1 || pm_addr !== 8'd1 || word_count !== 9'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_accept: rdy=%b addr=%0d cnt=%0d done=%b required 1 1 1 0",
               in_ready, pm_addr, word_count, done);
    end
    clear_log();
    send(4, 1, 2, 0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || word_count !== 9'd2 || wa_q.size() !== 1 || (wa_q.size() == 1 && wa_q[0] !== 8'd1)) begin
      errors++;
      $display("FAIL start_ignored_done: done=%b cnt=%0d writes=%0d required 1 2 1@addr1",
               done, word_count, wa_q.size());
    end
    do_start();
    checks++;
    if (done !== 1'b0 || word_count !== 9'd0 || pm_addr !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart: done=%b cnt=%0d addr=%0d rdy=%b required 0 0 0 1",
               done, word_count, pm_addr, in_ready);
    end
    send(0, 0, 0, 0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0]  ea[$];
    logic [15:0] ed[$];
    int op, a, b, p, nw;
    for (int s = 0; s < 4; s++) begin
      ea.delete(); ed.delete();
      clear_log();
      do_start();
      nw = $urandom_range(1, 10);
      for (int k = 0; k < nw; k++) begin
        do op = $urandom_range(0, 31); while (op_class(op) == 4);
        a = $urandom_range(0, 3); b = $urandom_range(0, 3); p = $urandom_range(0, 255);
        ea.push_back(8'(k));
        ed.push_back(model_word(op, a, b, p));
        send(op, a, b, p, (s[0] == 1'b0) && (k == nw - 1));
      end
      if (s[0] == 1'b1) begin
        do op = $urandom_range(0, 31); while (op_class(op) != 4);
        send(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255), 1'b1);
      end
      repeat (2) @(posedge clk); #1;
      check_log("random", ea, ed);
      checks++;
      if (s[0] == 1'b0 && (done !== 1'b1 || err !== 1'b0 || word_count !== 9'(nw))) begin
        errors++;
        $display("FAIL random_done: done=%b err=%b cnt=%0d required 1 0 %0d", done, err, word_count, nw);
      end else if (s[0] == 1'b1 && (err !== 1'b1 || err_code !== 2'b01 || word_count !== 9'(nw))) begin
        errors++;
        $display("FAIL random_err: err=%b code=%0d cnt=%0d required 1 1 %0d", err, err_code, word_count, nw);
      end
    end
  endtask

  initial begin
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = '0; in_op1 = '0; in_op2 = '0; in_param = '0;
    test_reset();
    test_single_add();
    test_back_to_back();
    test_reserved();
    test_overflow();
    test_reset_mid_write();
    test_start_ignored();
    test_random();
    checks++;
    if (consec !== 0) begin
      errors++; $display("FAIL wr_en_consecutive: count=%0d required 0", consec);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
